// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 op codes, FSM states and operand signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // MULHSU treats rs2 as unsigned
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, funct3, rs1, rs2, tag_in, flush, out_ready,
    input  in_ready, out_valid, result, tag_out
  );

  modport slave (
    input  in_valid, funct3, rs1, rs2, tag_in, flush, out_ready,
    output in_ready, out_valid, result, tag_out
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation over N lanes; gives operand magnitudes
// on the input side and restores result signs on the output side.
module muldiv_sign_fix #(
  parameter int W = 32,
  parameter int N = 1
) (
  input  logic [N-1:0][W-1:0] val,
  input  logic [N-1:0]        neg,
  output logic [N-1:0][W-1:0] res
);

  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      res[i] = neg[i] ? -val[i] : val[i];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one hi/lo register pair, with divide fast paths.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave io
);

  localparam int CNT_W = $clog2(XLEN + 1);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q, result_q;
  logic             neg_res_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic                 accept, sa, sb, div_zero, div_ovf, fast;
  logic [1:0][XLEN-1:0] op_raw, op_mag;
  logic [XLEN-1:0]      fast_res;
  logic [XLEN:0]        mul_sum, div_shift, div_trial;
  logic [XLEN-1:0]      hi_d, lo_d, final_res;
  logic [0:0][2*XLEN-1:0] fix_in, fix_out;
  logic [0:0]           fix_neg;

  // ---------------- input decode and magnitudes ----------------
  always_comb begin
    sa       = is_signed_a(io.funct3) && io.rs1[XLEN-1];
    sb       = is_signed_b(io.funct3) && io.rs2[XLEN-1];
    op_raw   = {io.rs2, io.rs1};
    div_zero = is_div(io.funct3) && (io.rs2 == '0);
    div_ovf  = ((io.funct3 == F3_DIV) || (io.funct3 == F3_REM)) &&
               (io.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.rs2 == '1);
    fast     = div_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (io.funct3[1]) fast_res = div_zero ? io.rs1 : '0;
    else              fast_res = div_zero ? '1 : io.rs1;
  end

  muldiv_sign_fix #(.W(XLEN), .N(2)) u_abs (
    .val (op_raw),
    .neg ({sb, sa}),
    .res (op_mag)
  );

  // ---------------- one iteration of the shared datapath ----------------
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, b_q};
    if (is_div(op_q)) begin
      hi_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~div_trial[XLEN]};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // The final iteration's value feeds the sign fix directly, so the fixed
  // result is captured on the same edge that enters DONE.
  always_comb begin
    if (is_div(op_q)) fix_in[0] = {{XLEN{1'b0}}, (op_q[1] ? hi_d : lo_d)};
    else              fix_in[0] = {hi_d, lo_d};
    fix_neg[0] = (is_div(op_q) && op_q[1]) ? neg_rem_q : neg_res_q;
  end

  muldiv_sign_fix #(.W(2*XLEN), .N(1)) u_fix (
    .val (fix_in),
    .neg (fix_neg),
    .res (fix_out)
  );

  always_comb begin
    if ((op_q == F3_MUL) || is_div(op_q)) final_res = fix_out[0][XLEN-1:0];
    else                                  final_res = fix_out[0][2*XLEN-1:XLEN];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = fast ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush) state_d = IDLE;
  end

  always_comb begin
    accept       = (state_q == IDLE) && io.in_valid && !io.flush;
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
    io.result    = result_q;
    io.tag_out   = tag_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      tag_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      result_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_q      <= io.funct3;
      tag_q     <= io.tag_in;
      neg_res_q <= sa ^ sb;
      neg_rem_q <= sa;
      cnt_q     <= CNT_W'(XLEN);
      hi_q      <= '0;
      if (is_div(io.funct3)) begin
        lo_q <= op_mag[0];
        b_q  <= op_mag[1];
      end else begin
        lo_q <= op_mag[1];
        b_q  <= op_mag[0];
      end
      if (fast) result_q <= fast_res;
    end else if ((state_q == CALC) && !io.flush) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) result_q <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against
// an arithmetic reference, back-pressure, flush and mid-op reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } dir_t;

  dir_t dir_vec [14] = '{
    '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000},
    '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{F3_DIVU,   32'd100,        32'd7,         32'd14},
    '{F3_REMU,   32'd100,        32'd7,         32'd2},
    '{F3_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF},
    '{F3_REM,    32'h1234_5678,  32'd0,         32'h1234_5678},
    '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF},
    '{F3_REMU,   32'd5,          32'd0,         32'd5},
    '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000}
  };

  // Reference: RISC-V M-extension results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Edges after the accept edge until out_valid is visible
  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    logic div_op, signed_op;
    div_op    = f3[2];
    signed_op = !f3[0];
    if (div_op && (b == 0 || (signed_op && a == MIN_INT && b == 32'hFFFF_FFFF)))
      return 0;
    return XLEN;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_INT;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drive one op, wait (bounded) for the result, then retire it.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg,
                        output logic [31:0] res, output logic [4:0] tg_o,
                        output int lat);
    bus.funct3   = f3;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.tag_in   = tg;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
    bus.tag_in   = 5'($urandom);
    bus.funct3   = 3'($urandom);
    lat = -1;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    res  = bus.result;
    tg_o = bus.tag_out;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.tag_out !== 5'd0) begin errors++; $display("FAIL reset_tag_out: got %h expected 00", bus.tag_out); end
  endtask

  task automatic test_directed;
    logic [31:0] res;
    logic [4:0]  tg;
    int lat, exp_lat;
    for (int i = 0; i < 14; i++) begin
      exp_lat = ref_latency(dir_vec[i].f3, dir_vec[i].a, dir_vec[i].b);
      run_op(dir_vec[i].f3, dir_vec[i].a, dir_vec[i].b, 5'(i + 1), res, tg, lat);
      checks++; if (res !== dir_vec[i].exp) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, dir_vec[i].exp); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      checks++; if (tg !== 5'(i + 1)) begin errors++; $display("FAIL directed_tag[%0d]: got %0d expected %0d", i, tg, i + 1); end
    end
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b, res, exp_res;
    logic [4:0]  tg, tg_in;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      f3      = 3'($urandom_range(0, 7));
      a       = pick_operand();
      b       = pick_operand();
      tg_in   = 5'($urandom);
      exp_res = ref_result(f3, a, b);
      exp_lat = ref_latency(f3, a, b);
      run_op(f3, a, b, tg_in, res, tg, lat);
      checks++; if (res !== exp_res) begin errors++; $display("FAIL random_result[%0d] f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, exp_res); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL random_latency[%0d] f3=%0d: got %0d expected %0d", i, f3, lat, exp_lat); end
      checks++; if (tg !== tg_in) begin errors++; $display("FAIL random_tag[%0d]: got %0d expected %0d", i, tg, tg_in); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b, exp_res, res;
    logic [4:0]  tg;
    logic seen;
    int lat;
    a = $urandom;
    b = $urandom;
    exp_res = ref_result(F3_MULHU, a, b);
    bus.funct3 = F3_MULHU; bus.rs1 = a; bus.rs2 = b; bus.tag_in = 5'd17;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_out_valid_timeout: got %b expected 1", seen); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.result !== exp_res) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h expected %h", i, bus.result, exp_res); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    checks++; if (bus.tag_out !== 5'd17) begin errors++; $display("FAIL bp_tag: got %0d expected 17", bus.tag_out); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
    run_op(F3_DIVU, 32'd1000, 32'd33, 5'd4, res, tg, lat);
    checks++; if (res !== 32'd30) begin errors++; $display("FAIL bp_second_result: got %h expected %h", res, 32'd30); end
    checks++; if (lat !== XLEN) begin errors++; $display("FAIL bp_second_latency: got %0d expected %0d", lat, XLEN); end
  endtask

  task automatic test_flush;
    logic seen;
    logic [31:0] res;
    logic [4:0]  tg;
    int lat;
    bus.funct3 = F3_DIVU; bus.rs1 = 32'd12345; bus.rs2 = 32'd7; bus.tag_in = 5'd9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_out_valid_seen: got %b expected 0", seen); end

    bus.funct3 = F3_DIV; bus.rs1 = 32'd5; bus.rs2 = 32'd0;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_accept_in_ready: got %b expected 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_accept_dropped: got %b expected 0", seen); end

    run_op(F3_REM, 32'hFFFF_FF9C, 32'd7, 5'd11, res, tg, lat);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL flush_after_result: got %h expected fffffffe", res); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    logic [4:0]  tg;
    int lat;
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd3, res, tg, lat);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL rstmid_pre_result: got %h expected 0000000e", res); end

    bus.funct3 = F3_MUL; bus.rs1 = 32'd123; bus.rs2 = 32'd456; bus.tag_in = 5'd21;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstcalc_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstcalc_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rstcalc_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.tag_out !== 5'd0) begin errors++; $display("FAIL rstcalc_tag_out: got %0d expected 0", bus.tag_out); end

    bus.funct3 = F3_DIV; bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'd0; bus.tag_in = 5'd13;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstdone_pre_valid: got %b expected 1", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstdone_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstdone_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rstdone_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.tag_out !== 5'd0) begin errors++; $display("FAIL rstdone_tag_out: got %0d expected 0", bus.tag_out); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct3    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.tag_in    = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
